div_datapath: RTL

- Iterative signed radix-2 non-restoring integer divider, the inverse operation of the team's sequential Booth multiplier.
- Shares the same start/done operand handshake, so the core's execute stage drives both units identically.
- Produces a WIDTH-bit quotient and remainder after a fixed latency.
- Operands are registered on start, so inputs may change afterwards.

---
 rtl/div_datapath.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_datapath.sv
// Iterative signed radix-2 non-restoring divider: WIDTH-bit quotient/remainder, fixed WIDTH+2 cycle latency.
// Optional unsigned mode (is_unsigned port) is enabled by defining DIV_UNSIGNED_EN.
`timescale 1ns/1ps

module div_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy,
    output logic             done
);

    // Unsigned operands reach 2^WIDTH-1, so the partial remainder needs one more guard bit.
`ifdef DIV_UNSIGNED_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH + 1;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] dvd_r, dvs_r;
    logic            uns_r;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]   p;
    logic            neg_a, neg_q, dz, ovf;

    logic            accept, uns_in, sign_a, sign_b;
    logic [PW-1:0]   ext_b, p_sh, p_step;
    logic [WIDTH-1:0] rem_mag;

`ifdef DIV_UNSIGNED_EN
    assign uns_in = is_unsigned;
`else
    assign uns_in = 1'b0;
`endif

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign sign_a = ~uns_r & dvd_r[WIDTH-1];
    assign sign_b = ~uns_r & dvs_r[WIDTH-1];

    // One non-restoring step: bring in the next dividend bit, then add or subtract by the sign of P.
    always_comb begin
        ext_b   = {{(PW-WIDTH){1'b0}}, mag_b};
        p_sh    = {p[PW-2:0], q[WIDTH-1]};
        p_step  = p[PW-1] ? (p_sh + ext_b) : (p_sh - ext_b);
        rem_mag = p[PW-1] ? (p[WIDTH-1:0] + mag_b) : p[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            S_PREP: begin
                busy      = 1'b1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = accept ? S_PREP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            uns_r       <= 1'b0;
            mag_b       <= '0;
            q           <= '0;
            p           <= '0;
            neg_a       <= 1'b0;
            neg_q       <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            if (accept) begin
                dvd_r <= dividend_i;
                dvs_r <= divisor_i;
                uns_r <= uns_in;
            end
            case (state)
                S_PREP: begin
                    neg_a <= sign_a;
                    neg_q <= sign_a ^ sign_b;
                    mag_b <= sign_b ? -dvs_r : dvs_r;
                    q     <= sign_a ? -dvd_r : dvd_r;
                    p     <= '0;
                    cnt   <= '0;
                    dz    <= (dvs_r == '0);
                    ovf   <= ~uns_r && (dvd_r == MIN_VAL) && (dvs_r == '1);
                end
                S_ITER: begin
                    p   <= p_step;
                    q   <= {q[WIDTH-2:0], ~p_step[PW-1]};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (dz) begin
                        quotient_o  <= '1;
                        remainder_o <= dvd_r;
                    end else if (ovf) begin
                        quotient_o  <= dvd_r;
                        remainder_o <= '0;
                    end else begin
                        quotient_o  <= neg_q ? -q : q;
                        remainder_o <= neg_a ? -rem_mag : rem_mag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
